// File: rtl/wb_target_sram.sv
// ---------------------------------------------------------------------------
// wb_target_sram
//
// Purpose:
//    Wishbone classic-cycle target made of a single-port word SRAM and a
//    programmable wait-state sequencer. It answers every request with an
//    acknowledge. Out-of-window writes are discarded, and out-of-window reads
//    return zero. Two saturating counters record completed writes and reads
//    for scoreboard cross-checks.
//
// Ports:
//    clock     in   1           single clock, all state on the rising edge
//    reset     in   1           asynchronous, active-low reset
//    adr       in   ADDR_WIDTH  byte address from the initiator (bits [1:0] ignored)
//    dat_w     in   DATA_WIDTH  write data
//    dat_r     out  DATA_WIDTH  read data, valid while ack=1 on a read
//    stb       in   1           strobe
//    cyc       in   1           bus cycle
//    we        in   1           1 = write, 0 = read
//    ack       out  1           transfer acknowledge
//    wr_count  out  CNT_WIDTH   completed writes, saturating
//    rd_count  out  CNT_WIDTH   completed reads, saturating
// ---------------------------------------------------------------------------
module wb_target_sram #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    DEPTH_LOG2  = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_STATES = 1,
   parameter int                    CNT_WIDTH   = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] adr,
   input  logic [DATA_WIDTH-1:0] dat_w,
   output logic [DATA_WIDTH-1:0] dat_r,
   input  logic                  stb,
   input  logic                  cyc,
   input  logic                  we,
   output logic                  ack,
   output logic [CNT_WIDTH-1:0]  wr_count,
   output logic [CNT_WIDTH-1:0]  rd_count
);

   localparam int         DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACK
   } state_t;

   state_t                  state;
   logic [3:0]              wcnt;

   logic                    lat_we;
   logic [DATA_WIDTH-1:0]   lat_dat;
   logic [DEPTH_LOG2-1:0]   lat_idx;
   logic                    lat_hit;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    req;
   logic [ADDR_WIDTH-1:0]   offset;
   logic                    hit_now;
   logic [DEPTH_LOG2-1:0]   idx_now;
   logic [DATA_WIDTH-1:0]   rd_now;
   logic [DATA_WIDTH-1:0]   rd_lat;

   // Address decode of the live bus address. The subtraction is done modulo
   // 2**ADDR_WIDTH, so an address below BASE_ADDR wraps to a large offset
   // and falls outside the window. In-window means that no offset bit above
   // the word index and the byte lane is set.
   always_comb begin
      req     = cyc & stb;
      offset  = adr - BASE_ADDR;
      hit_now = ((offset >> (DEPTH_LOG2 + 2)) == '0);
      idx_now = offset[DEPTH_LOG2+1:2];
   end

   // Read data candidates. One comes from the live address, for the
   // zero-wait case where ACK is entered straight from IDLE. The other comes
   // from the latched address, for the case where ACK is entered after
   // wait states.
   always_comb begin
      rd_now = hit_now ? mem[idx_now] : '0;
      rd_lat = lat_hit ? mem[lat_idx] : '0;
   end

   // The acknowledge is combinationally qualified by the live cyc/stb. If the
   // initiator withdraws during the ACK cycle, the access silently drops.
   always_comb begin
      ack = (state == ACK) & req;
   end

   // Main sequencer.
   // IDLE samples a request and latches it. WAIT counts the programmed wait
   // states down and aborts if the initiator withdraws. ACK lasts exactly one
   // cycle and always returns to IDLE, so IDLE lasts at least one cycle
   // between transfers. The counters step only on a qualified ACK cycle, and
   // they stick at all-ones. dat_r loads only on the edge that enters ACK for
   // a read, so it holds through writes.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         wcnt     <= '0;
         dat_r    <= '0;
         wr_count <= '0;
         rd_count <= '0;
         lat_we   <= 1'b0;
         lat_dat  <= '0;
         lat_idx  <= '0;
         lat_hit  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  lat_we  <= we;
                  lat_dat <= dat_w;
                  lat_idx <= idx_now;
                  lat_hit <= hit_now;
                  wcnt    <= WAIT_LOAD;
                  if (WAIT_LOAD == 4'd0) begin
                     state <= ACK;
                     if (!we) begin
                        dat_r <= rd_now;
                     end
                  end else begin
                     state <= WAIT;
                  end
               end
            end

            WAIT: begin
               if (!req) begin
                  state <= IDLE;
                  wcnt  <= '0;
               end else if (wcnt == 4'd1) begin
                  state <= ACK;
                  wcnt  <= '0;
                  if (!lat_we) begin
                     dat_r <= rd_lat;
                  end
               end else begin
                  wcnt <= wcnt - 4'd1;
               end
            end

            ACK: begin
               state <= IDLE;
               if (ack) begin
                  if (lat_we) begin
                     if (wr_count != '1) begin
                        wr_count <= wr_count + 1'b1;
                     end
                  end else begin
                     if (rd_count != '1) begin
                        rd_count <= rd_count + 1'b1;
                     end
                  end
               end
            end

            default: begin
               state <= IDLE;
               wcnt  <= '0;
            end
         endcase
      end
   end

   // SRAM write port. Contents are deliberately not reset. A write commits
   // on the edge that ends a qualified ACK cycle, and only for an in-window
   // address. While reset is asserted the sequencer sits in IDLE, so a
   // pending write can never land.
   always_ff @(posedge clock) begin
      if (ack && lat_we && lat_hit) begin
         mem[lat_idx] <= lat_dat;
      end
   end

endmodule

// File: tb/tb_wb_target_sram.sv
// ---------------------------------------------------------------------------
// tb_wb_target_sram
//
// Purpose:
//    Self-checking bench for wb_target_sram. It drives three instances:
//       d0: WAIT_STATES=1, BASE 0x0                basic access, window edge, reset abort
//       d1: WAIT_STATES=0, BASE 0x0                zero-wait latency
//       d2: WAIT_STATES=3, BASE 0x1000, CNT 4 bit  window, cyc abort, saturation
//    Each request pushes the expected acknowledge (instance, cycle and dat_r)
//    onto a scoreboard queue. A monitor pops an entry on every ack it sees.
// ---------------------------------------------------------------------------
module tb_wb_target_sram;

   logic              clock;
   logic [2:0]        rst_v;
   logic [2:0]        cyc_v;
   logic [2:0]        stb_v;
   logic [2:0]        we_v;
   logic [2:0][31:0]  adr_v;
   logic [2:0][31:0]  datw_v;
   wire  [2:0][31:0]  datr_v;
   wire  [2:0]        ack_v;
   wire  [2:0][15:0]  wrc_v;
   wire  [2:0][15:0]  rdc_v;
   wire  [3:0]        wrc2;
   wire  [3:0]        rdc2;

   assign wrc_v[2] = {12'd0, wrc2};
   assign rdc_v[2] = {12'd0, rdc2};

   typedef struct {
      int          dut;
      logic [31:0] dat;
      int          at;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          errors   = 0;
   int          cyc_cnt  = 0;
   int          exp_wr[3];
   int          exp_rd[3];
   logic [31:0] last_rd[3];
   int          cnt_max[3] = '{65535, 65535, 15};
   int          ws_of[3]   = '{1, 0, 3};

   wb_target_sram #(.WAIT_STATES(1)) u_d0 (
      .clock(clock), .reset(rst_v[0]), .adr(adr_v[0]), .dat_w(datw_v[0]),
      .dat_r(datr_v[0]), .stb(stb_v[0]), .cyc(cyc_v[0]), .we(we_v[0]),
      .ack(ack_v[0]), .wr_count(wrc_v[0]), .rd_count(rdc_v[0])
   );

   wb_target_sram #(.WAIT_STATES(0)) u_d1 (
      .clock(clock), .reset(rst_v[1]), .adr(adr_v[1]), .dat_w(datw_v[1]),
      .dat_r(datr_v[1]), .stb(stb_v[1]), .cyc(cyc_v[1]), .we(we_v[1]),
      .ack(ack_v[1]), .wr_count(wrc_v[1]), .rd_count(rdc_v[1])
   );

   wb_target_sram #(.BASE_ADDR(32'h1000), .WAIT_STATES(3), .CNT_WIDTH(4)) u_d2 (
      .clock(clock), .reset(rst_v[2]), .adr(adr_v[2]), .dat_w(datw_v[2]),
      .dat_r(datr_v[2]), .stb(stb_v[2]), .cyc(cyc_v[2]), .we(we_v[2]),
      .ack(ack_v[2]), .wr_count(wrc2), .rd_count(rdc2)
   );

   // Free-running clock and a cycle counter used to timestamp acknowledges.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) begin
      cyc_cnt <= cyc_cnt + 1;
   end

   // Compare one value against its expected value and report a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("[TB] FAIL %s got %h want %h at cycle %0d", name, act, want, cyc_cnt);
      end
   endtask

   // Monitor. It samples on the falling edge. Every ack must match the oldest
   // scoreboard entry for instance, cycle and dat_r.
   always @(negedge clock) begin
      exp_t e;
      for (int d = 0; d < 3; d++) begin
         if (ack_v[d] === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_ack dut%0d got ack=1 want ack=0 at cycle %0d", d, cyc_cnt);
            end else begin
               e = sb.pop_front();
               checkOutput("ack_dut", d, e.dut);
               checkOutput("ack_cycle", cyc_cnt, e.at);
               checkOutput("dat_r", datr_v[d], e.dat);
            end
         end
      end
   end

   // One classic-cycle transfer, driven just after a rising edge. The DUT
   // samples the request on the next edge, S. The ack must then appear in
   // the cycle after edge S+WAIT_STATES. The bench drops stb on the edge
   // that ends the ack cycle and checks the bench's own counter model.
   task automatic applyStimulus(input int d, input logic wr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd_exp);
      exp_t e;
      int   n;
      @(posedge clock);
      #1;
      adr_v[d]  = a;
      datw_v[d] = wd;
      we_v[d]   = wr;
      cyc_v[d]  = 1'b1;
      stb_v[d]  = 1'b1;
      if (!wr) begin
         last_rd[d] = rd_exp;
      end
      e.dut = d;
      e.dat = last_rd[d];
      e.at  = cyc_cnt + 1 + ws_of[d];
      sb.push_back(e);
      n = 0;
      while (ack_v[d] !== 1'b1 && n < 40) begin
         @(negedge clock);
         n++;
      end
      if (n >= 40) begin
         checks++;
         errors++;
         $display("[TB] FAIL ack_timeout dut%0d got no ack want ack within 40 cycles", d);
         void'(sb.pop_back());
      end
      @(posedge clock);
      #1;
      cyc_v[d] = 1'b0;
      stb_v[d] = 1'b0;
      if (n < 40) begin
         if (wr) begin
            exp_wr[d] = (exp_wr[d] < cnt_max[d]) ? exp_wr[d] + 1 : exp_wr[d];
         end else begin
            exp_rd[d] = (exp_rd[d] < cnt_max[d]) ? exp_rd[d] + 1 : exp_rd[d];
         end
      end
      checkOutput("wr_count", wrc_v[d], exp_wr[d]);
      checkOutput("rd_count", rdc_v[d], exp_rd[d]);
   endtask

   // Bound the whole run in case something stalls outside a bounded wait.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog got no finish want finish before 400us");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_v  = 3'b000;
      cyc_v  = 3'b000;
      stb_v  = 3'b000;
      we_v   = 3'b000;
      adr_v  = '0;
      datw_v = '0;
      for (int d = 0; d < 3; d++) begin
         exp_wr[d]  = 0;
         exp_rd[d]  = 0;
         last_rd[d] = 32'h0;
      end
      repeat (3) @(posedge clock);
      #1;
      for (int d = 0; d < 3; d++) begin
         checkOutput("reset_ack", ack_v[d], 32'h0);
         checkOutput("reset_dat_r", datr_v[d], 32'h0);
         checkOutput("reset_wr_count", wrc_v[d], 32'h0);
         checkOutput("reset_rd_count", rdc_v[d], 32'h0);
      end
      rst_v = 3'b111;

      // Basic write/read-back with one wait state, sub-word address bits and the window edge
      $display("[TB] d0 basic write/read-back");
      applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0);
      applyStimulus(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
      applyStimulus(0, 1'b1, 32'h14, 32'hA5A5A5A5, 32'h0);
      applyStimulus(0, 1'b0, 32'h13, 32'h0, 32'hDEADBEEF);
      applyStimulus(0, 1'b0, 32'h14, 32'h0, 32'hA5A5A5A5);
      applyStimulus(0, 1'b1, 32'h3FC, 32'h0000FFFF, 32'h0);
      applyStimulus(0, 1'b0, 32'h3FC, 32'h0, 32'h0000FFFF);
      applyStimulus(0, 1'b0, 32'h400, 32'h0, 32'h0);

      // Zero wait states
      $display("[TB] d1 zero-wait latency");
      applyStimulus(1, 1'b1, 32'h8, 32'h0BADF00D, 32'h0);
      applyStimulus(1, 1'b0, 32'h8, 32'h0, 32'h0BADF00D);

      // Offset window at 0x1000, three wait states
      $display("[TB] d2 window checks");
      applyStimulus(2, 1'b1, 32'h1000, 32'hAAAA5555, 32'h0);
      applyStimulus(2, 1'b1, 32'h1400, 32'h00000055, 32'h0);
      applyStimulus(2, 1'b0, 32'h1000, 32'h0, 32'hAAAA5555);
      applyStimulus(2, 1'b0, 32'h1400, 32'h0, 32'h0);
      applyStimulus(2, 1'b0, 32'h0FFC, 32'h0, 32'h0);
      applyStimulus(2, 1'b1, 32'h13FC, 32'h600DCAFE, 32'h0);
      applyStimulus(2, 1'b0, 32'h13FC, 32'h0, 32'h600DCAFE);

      // cyc withdrawn in the second wait cycle: no ack, no write, no count
      $display("[TB] d2 cyc abort");
      applyStimulus(2, 1'b1, 32'h1020, 32'hCAFE0001, 32'h0);
      @(posedge clock);
      #1;
      adr_v[2]  = 32'h1020;
      datw_v[2] = 32'h12345678;
      we_v[2]   = 1'b1;
      cyc_v[2]  = 1'b1;
      stb_v[2]  = 1'b1;
      @(posedge clock);
      @(posedge clock);
      #1;
      cyc_v[2] = 1'b0;
      stb_v[2] = 1'b0;
      repeat (6) @(posedge clock);
      #1;
      checkOutput("abort_wr_count", wrc_v[2], exp_wr[2]);
      applyStimulus(2, 1'b0, 32'h1020, 32'h0, 32'hCAFE0001);

      // Reset asserted during a wait cycle discards the pending write
      $display("[TB] d0 reset during wait");
      applyStimulus(0, 1'b1, 32'h40, 32'h11112222, 32'h0);
      applyStimulus(0, 1'b0, 32'h40, 32'h0, 32'h11112222);
      @(posedge clock);
      #1;
      adr_v[0]  = 32'h40;
      datw_v[0] = 32'h77777777;
      we_v[0]   = 1'b1;
      cyc_v[0]  = 1'b1;
      stb_v[0]  = 1'b1;
      @(posedge clock);
      #2;
      rst_v[0] = 1'b0;
      #1;
      checkOutput("rst_ack", ack_v[0], 32'h0);
      checkOutput("rst_wr_count", wrc_v[0], 32'h0);
      checkOutput("rst_rd_count", rdc_v[0], 32'h0);
      checkOutput("rst_dat_r", datr_v[0], 32'h0);
      exp_wr[0]  = 0;
      exp_rd[0]  = 0;
      last_rd[0] = 32'h0;
      cyc_v[0]   = 1'b0;
      stb_v[0]   = 1'b0;
      @(posedge clock);
      #1;
      rst_v[0] = 1'b1;
      applyStimulus(0, 1'b0, 32'h40, 32'h0, 32'h11112222);

      // Four-bit write counter saturates at 15 and holds
      $display("[TB] d2 counter saturation");
      @(posedge clock);
      #1;
      rst_v[2] = 1'b0;
      @(posedge clock);
      #1;
      rst_v[2]   = 1'b1;
      exp_wr[2]  = 0;
      exp_rd[2]  = 0;
      last_rd[2] = 32'h0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(2, 1'b1, 32'h1000 + 32'(4 * i), 32'(i + 100), 32'h0);
      end
      checkOutput("sat_wr_count", wrc_v[2], 32'd15);
      checkOutput("sat_rd_count", rdc_v[2], 32'd0);
      applyStimulus(2, 1'b0, 32'h1004, 32'h0, 32'd101);

      repeat (5) @(posedge clock);
      #1;
      checkOutput("scoreboard_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
